// File: rtl/bldc_pkg.sv
// Shared types and lookup functions for the BLDC commutation sequencer.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package bldc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_FLT   = 2'd3
  } state_e;

  // Reported on SECTOR whenever the bridge is not being driven.
  localparam logic [2:0] SECTOR_NONE = 3'd7;

  // Decoded Hall code: valid flag plus sector 0..5.
  typedef struct packed {
    logic       vld;
    logic [2:0] sector;
  } hall_dec_t;

  localparam hall_dec_t HALL_DEC_NONE = '{vld: 1'b0, sector: SECTOR_NONE};

  // Per-phase drive bits, bit 2 = phase A, bit 1 = B, bit 0 = C.
  typedef struct packed {
    logic [2:0] hi;
    logic [2:0] lo;
  } drive_t;

  // Hall code {H3,H2,H1} to sector; 000 and 111 are physically impossible.
  function automatic hall_dec_t hall_decode(input logic [2:0] code);
    hall_dec_t r;
    r.vld = 1'b1;
    case (code)
      3'b101:  r.sector = 3'd0;
      3'b100:  r.sector = 3'd1;
      3'b110:  r.sector = 3'd2;
      3'b010:  r.sector = 3'd3;
      3'b011:  r.sector = 3'd4;
      3'b001:  r.sector = 3'd5;
      default: r = HALL_DEC_NONE;
    endcase
    return r;
  endfunction

  // Commutation table; reverse swaps which phase is high and which is low.
  // Each entry has exactly one high phase and a different low phase.
  function automatic drive_t comm_mask(input logic [2:0] sector, input logic dir);
    drive_t fwd;
    case (sector)
      3'd0:    fwd = {3'b100, 3'b010};  // A+, BB
      3'd1:    fwd = {3'b100, 3'b001};  // A+, CC
      3'd2:    fwd = {3'b010, 3'b001};  // B+, CC
      3'd3:    fwd = {3'b010, 3'b100};  // B+, AA
      3'd4:    fwd = {3'b001, 3'b100};  // C+, AA
      3'd5:    fwd = {3'b001, 3'b010};  // C+, BB
      default: fwd = '0;
    endcase
    return dir ? {fwd.lo, fwd.hi} : fwd;
  endfunction

endpackage

// File: rtl/bldc_hall_sync.sv
// Hall pin synchronizer with registered sector decode and validity flag.
// Latency: 2 clocks from a Hall pin change to updated hall_sector/hall_vld.
// Backpressure: none; samples every clock.
module bldc_hall_sync
  import bldc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall_raw,
  output logic       hall_vld,
  output logic [2:0] hall_sector
);

  logic [2:0] meta_q, meta_d;
  hall_dec_t  dec_q, dec_d;

  // First stage captures the raw pins; second stage holds the decoded code.
  always_comb begin
    meta_d = hall_raw;
    dec_d  = hall_decode(meta_q);
  end

  // Synchronizer and decode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 3'b000;
      dec_q  <= HALL_DEC_NONE;
    end else begin
      meta_q <= meta_d;
      dec_q  <= dec_d;
    end
  end

  assign hall_vld    = dec_q.vld;
  assign hall_sector = dec_q.sector;

endmodule

// File: rtl/bldc_commutation_seq.sv
// Three-phase BLDC commutation sequencer with dead-time, PWM, Hall fault and stall detection.
// Latency: Hall edge reaches the FSM 2 clocks later; drives are registered one clock after state.
// Backpressure: none; inputs sampled every clock, outputs always valid.
module bldc_commutation_seq
  import bldc_pkg::*;
#(
  parameter int unsigned DEAD_CYC  = 4,
  parameter int unsigned STALL_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       H1,
  input  logic       H2,
  input  logic       H3,
  input  logic [3:0] D,
  input  logic       EN,
  input  logic       DIR,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       AA,
  output logic       BB,
  output logic       CC,
  output logic       FAULT,
  output logic [2:0] SECTOR
);

  localparam int unsigned      STALL_W    = $clog2(STALL_CYC + 1);
  // Fault fires on the clock that would make the count reach STALL_CYC, so the
  // FSM spends exactly STALL_CYC clocks in DRIVE before entering FLT.
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYC - 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYC);
  localparam logic [7:0]         DEAD_LOAD  = 8'(DEAD_CYC);

  logic       hall_vld;
  logic [2:0] hall_sector;

  bldc_hall_sync u_hall_sync (
    .clk         (CLK),
    .rst         (RST),
    .hall_raw    ({H3, H2, H1}),
    .hall_vld    (hall_vld),
    .hall_sector (hall_sector)
  );

  state_e               state_q, state_d;
  logic [7:0]           dead_cnt_q, dead_cnt_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [3:0]           pwm_cnt_q, pwm_cnt_d;
  logic [2:0]           cur_sector_q, cur_sector_d;
  drive_t               drv_q, drv_d;
  logic                 fault_q, fault_d;
  logic [2:0]           sector_out_q, sector_out_d;

  logic sector_chg;
  logic stall_hit;

  assign sector_chg = hall_vld && (hall_sector != cur_sector_q);
  assign stall_hit  = (stall_cnt_q >= STALL_LAST);

  // Next-state logic: exit priority is EN low, invalid Hall, stall, sector change.
  always_comb begin
    state_d      = state_q;
    dead_cnt_d   = dead_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    cur_sector_d = cur_sector_q;
    case (state_q)
      ST_IDLE: begin
        dead_cnt_d  = '0;
        stall_cnt_d = '0;
        if (EN && hall_vld) begin
          state_d      = ST_DEAD;
          dead_cnt_d   = DEAD_LOAD;
          cur_sector_d = hall_sector;
        end
      end
      ST_DEAD: begin
        if (!EN) begin
          state_d = ST_IDLE;
        end else if (!hall_vld) begin
          state_d = ST_FLT;
        end else if (sector_chg) begin
          dead_cnt_d   = DEAD_LOAD;
          cur_sector_d = hall_sector;
        end else if (dead_cnt_q <= 8'd1) begin
          state_d     = ST_DRIVE;
          stall_cnt_d = '0;
        end else begin
          dead_cnt_d = dead_cnt_q - 8'd1;
        end
      end
      ST_DRIVE: begin
        if (!EN) begin
          state_d = ST_IDLE;
        end else if (!hall_vld || stall_hit) begin
          state_d = ST_FLT;
        end else if (sector_chg) begin
          state_d      = ST_DEAD;
          dead_cnt_d   = DEAD_LOAD;
          cur_sector_d = hall_sector;
        end else if (stall_cnt_q != STALL_MAX) begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
      end
      ST_FLT: begin
        dead_cnt_d  = '0;
        stall_cnt_d = '0;
        if (!EN) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PWM carrier: free-running 4-bit counter.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
  end

  // Output decode from the current state; registered below so every pin is a flop.
  always_comb begin
    drv_d        = '0;
    fault_d      = (state_q == ST_FLT);
    sector_out_d = SECTOR_NONE;
    if (state_q == ST_DRIVE) begin
      drv_d        = comm_mask(cur_sector_q, DIR);
      sector_out_d = cur_sector_q;
      if (!(pwm_cnt_q < D)) begin
        drv_d.hi = '0;
      end
    end
  end

  // State, counters and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      dead_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      pwm_cnt_q    <= '0;
      cur_sector_q <= SECTOR_NONE;
      drv_q        <= '0;
      fault_q      <= 1'b0;
      sector_out_q <= SECTOR_NONE;
    end else begin
      state_q      <= state_d;
      dead_cnt_q   <= dead_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      cur_sector_q <= cur_sector_d;
      drv_q        <= drv_d;
      fault_q      <= fault_d;
      sector_out_q <= sector_out_d;
    end
  end

  assign {A, B, C}    = drv_q.hi;
  assign {AA, BB, CC} = drv_q.lo;
  assign FAULT        = fault_q;
  assign SECTOR       = sector_out_q;

endmodule

// File: tb/tb_bldc_commutation_seq.sv
// Directed bench for bldc_commutation_seq: reset, rotation, reverse, duty, faults, stall.
// Two instances share the stimulus; the second uses a short stall limit.
// Shoot-through is checked on both instances every cycle.
module tb_bldc_commutation_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] hall;
  logic [3:0] d;
  logic       en;
  logic       dir;

  logic       a, b, c, aa, bb, cc, fault;
  logic [2:0] sector;
  logic       s_a, s_b, s_c, s_aa, s_bb, s_cc, s_fault;
  logic [2:0] s_sector;

  logic [5:0] drv;
  logic [5:0] s_drv;
  assign drv   = {a, b, c, aa, bb, cc};
  assign s_drv = {s_a, s_b, s_c, s_aa, s_bb, s_cc};

  int n_cmp = 0;
  int n_bad = 0;
  int hi_cnt, lo_cnt, stray, zeros, cyc;

  // Hall codes in forward order and the expected drive per sector ({A,B,C} / {AA,BB,CC}).
  logic [2:0] hall_tab [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  logic [2:0] fwd_hi   [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
  logic [2:0] fwd_lo   [6] = '{3'b010, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010};

  always #5 clk = ~clk;

  bldc_commutation_seq #(.DEAD_CYC(4), .STALL_CYC(100000)) u_dut (
    .CLK(clk), .RST(rst), .H1(hall[0]), .H2(hall[1]), .H3(hall[2]),
    .D(d), .EN(en), .DIR(dir),
    .A(a), .B(b), .C(c), .AA(aa), .BB(bb), .CC(cc),
    .FAULT(fault), .SECTOR(sector)
  );

  bldc_commutation_seq #(.DEAD_CYC(4), .STALL_CYC(50)) u_stall (
    .CLK(clk), .RST(rst), .H1(hall[0]), .H2(hall[1]), .H3(hall[2]),
    .D(d), .EN(en), .DIR(dir),
    .A(s_a), .B(s_b), .C(s_c), .AA(s_aa), .BB(s_bb), .CC(s_cc),
    .FAULT(s_fault), .SECTOR(s_sector)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_acc();
    hi_cnt = 0;
    lo_cnt = 0;
    stray  = 0;
  endtask

  // Sample the main instance once against an expected high/low phase pair.
  task automatic acc(input logic [2:0] hi_exp, input logic [2:0] lo_exp);
    if ((drv[5:3] & hi_exp) != 3'b000) hi_cnt++;
    if (drv[2:0] == lo_exp) lo_cnt++;
    if (((drv[5:3] & ~hi_exp) != 3'b000) || ((drv[2:0] & ~lo_exp) != 3'b000)) stray++;
  endtask

  task automatic measure(input int n, input logic [2:0] hi_exp, input logic [2:0] lo_exp);
    clear_acc();
    repeat (n) begin
      step(1);
      acc(hi_exp, lo_exp);
    end
  endtask

  // No phase may drive high and low together, on either instance.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      assert (((a & aa) | (b & bb) | (c & cc) | (s_a & s_aa) | (s_b & s_bb) | (s_c & s_cc)) == 1'b0)
      else begin
        n_bad++;
        $error("FAIL shoot_through: observed dut=%b stall=%b expected no overlap", drv, s_drv);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    dir  = 1'b0;
    d    = 4'd8;
    hall = 3'b101;
    step(2);
    rst = 1'b0;
    step(1);
    check("rst_drv", int'(drv), 0);
    check("rst_sector", int'(sector), 7);
    check("rst_fault", int'(fault), 0);
    step(5);
    check("idle_drv", int'(drv), 0);
    check("idle_sector", int'(sector), 7);

    // Forward entry: IDLE->DEAD one edge after EN, 4 dead clocks, drive one edge later.
    en = 1'b1;
    step(5);
    check("fwd_entry_dead", int'(drv), 0);
    step(1);
    check("fwd_entry_lo", int'(drv[2:0]), int'(fwd_lo[0]));
    check("fwd_entry_sector", int'(sector), 0);
    measure(16, fwd_hi[0], fwd_lo[0]);
    check("fwd0_duty", hi_cnt, 8);
    check("fwd0_lo", lo_cnt, 16);
    check("fwd0_stray", stray, 0);
    step(1000 - 6 - 16);

    // Forward rotation through all six sectors and back to 0.
    for (int i = 1; i <= 6; i++) begin
      hall = hall_tab[i % 6];
      step(3);
      check($sformatf("fwd%0d_old_lo", i), int'(drv[2:0]), int'(fwd_lo[(i - 1) % 6]));
      zeros = 0;
      step(1);
      while (drv == 6'd0 && zeros < 20) begin
        zeros++;
        step(1);
      end
      check($sformatf("fwd%0d_dead", i), zeros, 4);
      check($sformatf("fwd%0d_new_lo", i), int'(drv[2:0]), int'(fwd_lo[i % 6]));
      check($sformatf("fwd%0d_sector", i), int'(sector), i % 6);
      measure(16, fwd_hi[i % 6], fwd_lo[i % 6]);
      check($sformatf("fwd%0d_duty", i), hi_cnt, 8);
      check($sformatf("fwd%0d_lo_on", i), lo_cnt, 16);
      check($sformatf("fwd%0d_stray", i), stray, 0);
      step(1000 - 4 - zeros - 16);
    end

    // EN falling: drives still on the edge that samples it, off one clock later.
    en = 1'b0;
    step(1);
    check("en_fall_same_edge", int'(drv[2:0]), int'(fwd_lo[0]));
    step(1);
    check("en_fall_next_edge", int'(drv), 0);
    check("en_fall_sector", int'(sector), 7);
    check("en_fall_stall_fault_clr", int'(s_fault), 0);

    // Reverse, Hall held at 101: B+ with AA; the short-stall instance faults 50 clocks in.
    dir = 1'b1;
    step(2);
    en = 1'b1;
    step(5);
    check("rev_entry_dead", int'(drv), 0);
    step(1);
    check("rev_entry_lo", int'(drv[2:0]), 3'b100);
    check("stall_entry_lo", int'(s_drv[2:0]), 3'b100);
    clear_acc();
    cyc = 0;
    while (!s_fault && cyc < 200) begin
      step(1);
      cyc++;
      if (cyc <= 16) acc(3'b010, 3'b100);
    end
    check("rev_duty", hi_cnt, 8);
    check("rev_lo_on", lo_cnt, 16);
    check("rev_stray", stray, 0);
    check("stall_latency", cyc, 50);
    check("stall_drv", int'(s_drv), 0);
    check("stall_sector", int'(s_sector), 7);
    check("main_no_stall", int'(fault), 0);

    // Duty extremes on the running reverse drive.
    d = 4'd0;
    step(2);
    measure(16, 3'b010, 3'b100);
    check("d0_hi", hi_cnt, 0);
    check("d0_lo", lo_cnt, 16);
    d = 4'd15;
    step(2);
    measure(32, 3'b010, 3'b100);
    check("d15_hi", hi_cnt, 30);
    check("d15_lo", lo_cnt, 32);
    check("d15_stray", stray, 0);

    // Invalid Hall 111 while driving: FAULT and drives off 3 edges after the first sampling edge.
    hall = 3'b111;
    step(3);
    check("inv_pre_fault", int'(fault), 0);
    check("inv_pre_lo", int'(drv[2:0]), 3'b100);
    step(1);
    check("inv_fault", int'(fault), 1);
    check("inv_drv", int'(drv), 0);
    hall = 3'b101;
    step(10);
    check("inv_sticky", int'(fault), 1);
    check("inv_sticky_drv", int'(drv), 0);
    check("inv_sticky_sector", int'(sector), 7);

    // Reset while in FLT clears everything.
    rst = 1'b1;
    step(1);
    check("rst_flt_fault", int'(fault), 0);
    check("rst_flt_drv", int'(drv), 0);
    check("rst_flt_sector", int'(sector), 7);
    rst = 1'b0;

    // Reset in the middle of DEAD, then full re-entry timing from a cleared synchronizer.
    step(4);
    rst = 1'b1;
    step(1);
    check("rst_dead_drv", int'(drv), 0);
    check("rst_dead_sector", int'(sector), 7);
    rst = 1'b0;
    step(7);
    check("reentry_dead", int'(drv), 0);
    step(1);
    check("reentry_lo", int'(drv[2:0]), 3'b100);

    // Sector change during DEAD reloads the dead counter: 6 dead clocks instead of 4.
    hall = 3'b100;
    step(2);
    hall = 3'b110;
    step(2);
    zeros = 0;
    while (drv == 6'd0 && zeros < 20) begin
      zeros++;
      step(1);
    end
    check("reload_dead", zeros, 6);
    check("reload_lo", int'(drv[2:0]), 3'b010);
    check("reload_sector", int'(sector), 2);

    // Invalid 000 then EN low clears FAULT.
    hall = 3'b000;
    step(4);
    check("inv0_fault", int'(fault), 1);
    en = 1'b0;
    step(1);
    check("inv0_fault_hold", int'(fault), 1);
    step(1);
    check("en_clear_fault", int'(fault), 0);
    check("en_clear_drv", int'(drv), 0);
    check("en_clear_sector", int'(sector), 7);
    hall = 3'b101;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
